// File: rtl/mem_access_stage_if.sv
// Bundles every signal of the MEM stage except clk and rst.
// The EX op bus, the data-memory port and the WB result bus.
// Modport slave is the MEM stage's view. Modport master is the surrounding pipeline/memory view.
//   EX  : ex_valid/ex_ready handshake, ex_op, ex_funct3, ex_addr, ex_wdata, ex_result, ex_rd
//   DMEM: dmem_req/dmem_gnt (same-cycle grant), dmem_we, dmem_be, dmem_addr, dmem_wdata,
//         dmem_rvalid/dmem_rdata (load response)
//   WB  : wb_valid/wb_ready handshake, wb_we, wb_rd, wb_data, wb_exc, wb_exc_cause
interface mem_access_stage_if;
   // EX -> MEM
   logic        ex_valid;
   logic        ex_ready;
   logic [1:0]  ex_op;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_addr;
   logic [31:0] ex_wdata;
   logic [31:0] ex_result;
   logic [4:0]  ex_rd;
   // MEM <-> data memory
   logic        dmem_req;
   logic        dmem_gnt;
   logic        dmem_we;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;
   // MEM -> WB
   logic        wb_valid;
   logic        wb_ready;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        wb_exc;
   logic [1:0]  wb_exc_cause;

   // Pipeline / memory side
   modport master (
      output ex_valid, ex_op, ex_funct3, ex_addr, ex_wdata, ex_result, ex_rd,
      input  ex_ready,
      input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
      output dmem_gnt, dmem_rvalid, dmem_rdata,
      input  wb_valid, wb_we, wb_rd, wb_data, wb_exc, wb_exc_cause,
      output wb_ready
   );

   // MEM stage side
   modport slave (
      input  ex_valid, ex_op, ex_funct3, ex_addr, ex_wdata, ex_result, ex_rd,
      output ex_ready,
      output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
      input  dmem_gnt, dmem_rvalid, dmem_rdata,
      output wb_valid, wb_we, wb_rd, wb_data, wb_exc, wb_exc_cause,
      input  wb_ready
   );
endinterface

// File: rtl/mem_access_stage.sv
// RV32I MEM stage. It turns EX load/store/pass-through ops into data-memory requests.
// It formats load data and flags illegal or misaligned accesses.
// Every result is registered once per instruction for WB.
// Latency: pass-through/store/exception produce a result 1 cycle after acceptance.
//          A load's result appears on the edge that samples dmem_rvalid.
// Backpressure: EX is stalled while the WB register is full and not drained.
//          EX is also stalled while a load is outstanding, and when a memory op is not granted.
// Ports: clk, rst (async, active-low), bus (mem_access_stage_if.slave: EX, DMEM and WB groups).
// Optional macro MEM_TOHOST_EN adds the tohost_done/tohost_pass outputs.
// These outputs monitor a sw to TOHOST_ADDR.
module mem_access_stage #(
   parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000
) (
   input  logic                 clk,
   input  logic                 rst,
   mem_access_stage_if.slave    bus
`ifdef MEM_TOHOST_EN
   ,
   output logic                 tohost_done,
   output logic                 tohost_pass
`endif
);

   typedef enum logic {IDLE = 1'b0, LOAD_WAIT = 1'b1} state_t;

   localparam logic [1:0] OP_LOAD  = 2'd1;
   localparam logic [1:0] OP_STORE = 2'd2;

   localparam logic [1:0] CAUSE_LD_MISALIGN = 2'd1;
   localparam logic [1:0] CAUSE_ST_MISALIGN = 2'd2;
   localparam logic [1:0] CAUSE_ILLEGAL     = 2'd3;

   state_t      state;
   state_t      state_nxt;

   // Decode of the op currently presented by EX
   logic        is_load;
   logic        is_store;
   logic        illegal;
   logic        misaligned;
   logic        mem_op;
   logic [1:0]  off;

   // Handshake terms
   logic        out_free;
   logic        ex_ready_c;
   logic        dmem_req_c;
   logic        accept;
   logic        load_start;
   logic        load_done;

   // Request formatting
   logic [3:0]  req_be;
   logic [31:0] st_wdata;

   // Context of the outstanding load
   logic [2:0]  ld_funct3;
   logic [1:0]  ld_off;
   logic [4:0]  ld_rd;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;

   // WB result register
   logic        wb_valid_q;
   logic        wb_we_q;
   logic [4:0]  wb_rd_q;
   logic [31:0] wb_data_q;
   logic        wb_exc_q;
   logic [1:0]  wb_cause_q;

   // ------------------------------------------------------------------
   // Op decode
   // ------------------------------------------------------------------
   assign is_load  = (bus.ex_op == OP_LOAD);
   assign is_store = (bus.ex_op == OP_STORE);
   assign off      = bus.ex_addr[1:0];

   always_comb begin
      illegal = 1'b0;
      if (is_load) begin
         illegal = (bus.ex_funct3 == 3'd3) || (bus.ex_funct3 == 3'd6) ||
                   (bus.ex_funct3 == 3'd7);
      end else if (is_store) begin
         illegal = (bus.ex_funct3 > 3'd2);
      end
   end

   // funct3[1:0] encodes the access size for every legal load/store.
   // An illegal funct3 may also read as misaligned, but illegal wins when the cause is chosen.
   always_comb begin
      misaligned = 1'b0;
      if (is_load || is_store) begin
         case (bus.ex_funct3[1:0])
            2'd1:    misaligned = bus.ex_addr[0];
            2'd2:    misaligned = (bus.ex_addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
         endcase
      end
   end

   // Only legal, aligned loads/stores go to memory. Everything else completes locally.
   assign mem_op = (is_load || is_store) && !illegal && !misaligned;

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (load_start)       state_nxt = LOAD_WAIT;
         LOAD_WAIT: if (bus.dmem_rvalid)  state_nxt = IDLE;
         default:                         state_nxt = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------
   // The WB slot is free if it is empty or being drained this cycle.
   // This allows one op per cycle while WB keeps up.
   assign out_free = !wb_valid_q || bus.wb_ready;

   always_comb begin
      ex_ready_c = 1'b0;
      dmem_req_c = 1'b0;
      if (state == IDLE) begin
         dmem_req_c = bus.ex_valid && out_free && mem_op;
         ex_ready_c = out_free && (!mem_op || bus.dmem_gnt);
      end
   end

   assign accept     = bus.ex_valid && ex_ready_c;
   assign load_start = accept && is_load && mem_op;
   // A response outside LOAD_WAIT is stale (e.g. from before a reset) and is dropped.
   assign load_done  = (state == LOAD_WAIT) && bus.dmem_rvalid;

   // ------------------------------------------------------------------
   // Request formatting: lanes from size/offset, store data replicated
   // ------------------------------------------------------------------
   always_comb begin
      req_be   = 4'hF;
      st_wdata = bus.ex_wdata;
      case (bus.ex_funct3[1:0])
         2'd0: begin
            req_be   = 4'b0001 << off;
            st_wdata = {4{bus.ex_wdata[7:0]}};
         end
         2'd1: begin
            req_be   = 4'b0011 << off;
            st_wdata = {2{bus.ex_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   assign bus.ex_ready   = ex_ready_c;
   assign bus.dmem_req   = dmem_req_c;
   assign bus.dmem_we    = is_store;
   assign bus.dmem_be    = req_be;
   assign bus.dmem_addr  = {bus.ex_addr[31:2], 2'b00};
   assign bus.dmem_wdata = st_wdata;

   // ------------------------------------------------------------------
   // Outstanding load context
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ld_funct3 <= 3'd0;
         ld_off    <= 2'd0;
         ld_rd     <= 5'd0;
      end else if (load_start) begin
         ld_funct3 <= bus.ex_funct3;
         ld_off    <= off;
         ld_rd     <= bus.ex_rd;
      end
   end

   // Load extraction: the byte is picked by the full offset, the half by offset bit 1.
   // funct3[2] selects zero extension.
   always_comb begin
      ld_byte = bus.dmem_rdata[{ld_off, 3'b000} +: 8];
      ld_half = bus.dmem_rdata[{ld_off[1], 4'b0000} +: 16];
      case (ld_funct3)
         3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
         3'd4:    ld_data = {24'h0, ld_byte};
         3'd5:    ld_data = {16'h0, ld_half};
         default: ld_data = bus.dmem_rdata;
      endcase
   end

   // ------------------------------------------------------------------
   // WB result register
   // ------------------------------------------------------------------
   // A load acceptance falls through to the drain branch. The slot was free,
   // so it empties and stays empty until the response arrives.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_valid_q <= 1'b0;
         wb_we_q    <= 1'b0;
         wb_rd_q    <= 5'd0;
         wb_data_q  <= 32'd0;
         wb_exc_q   <= 1'b0;
         wb_cause_q <= 2'd0;
      end else if (accept && !load_start) begin
         wb_valid_q <= 1'b1;
         wb_rd_q    <= bus.ex_rd;
         if (illegal || misaligned) begin
            // Faulting address is kept in wb_data for the trap handler
            wb_we_q    <= 1'b0;
            wb_exc_q   <= 1'b1;
            wb_data_q  <= bus.ex_addr;
            wb_cause_q <= illegal ? CAUSE_ILLEGAL :
                          (is_load ? CAUSE_LD_MISALIGN : CAUSE_ST_MISALIGN);
         end else if (is_store) begin
            wb_we_q    <= 1'b0;
            wb_exc_q   <= 1'b0;
            wb_data_q  <= 32'd0;
            wb_cause_q <= 2'd0;
         end else begin
            // ALU pass-through, including the reserved op encoding
            wb_we_q    <= (bus.ex_rd != 5'd0);
            wb_exc_q   <= 1'b0;
            wb_data_q  <= bus.ex_result;
            wb_cause_q <= 2'd0;
         end
      end else if (load_done) begin
         wb_valid_q <= 1'b1;
         wb_we_q    <= (ld_rd != 5'd0);
         wb_rd_q    <= ld_rd;
         wb_data_q  <= ld_data;
         wb_exc_q   <= 1'b0;
         wb_cause_q <= 2'd0;
      end else if (bus.wb_ready) begin
         wb_valid_q <= 1'b0;
      end
   end

   assign bus.wb_valid     = wb_valid_q;
   assign bus.wb_we        = wb_we_q;
   assign bus.wb_rd        = wb_rd_q;
   assign bus.wb_data      = wb_data_q;
   assign bus.wb_exc       = wb_exc_q;
   assign bus.wb_exc_cause = wb_cause_q;

   // ------------------------------------------------------------------
   // Test-completion monitor
   // ------------------------------------------------------------------
`ifdef MEM_TOHOST_EN
   // Only the first granted sw to TOHOST_ADDR is recorded. Later writes cannot change the verdict.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tohost_done <= 1'b0;
         tohost_pass <= 1'b0;
      end else if (dmem_req_c && bus.dmem_gnt && is_store &&
                   (bus.ex_funct3 == 3'd2) && (bus.ex_addr == TOHOST_ADDR) &&
                   !tohost_done) begin
         tohost_done <= 1'b1;
         tohost_pass <= (bus.ex_wdata == 32'd1);
      end
   end
`else
   logic unused_tohost_addr;
   assign unused_tohost_addr = ^TOHOST_ADDR;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios, then a randomized stream.
// The randomized stream is checked against a queue-based model of the WB slot.
// Inputs change on the falling edge and outputs are sampled 1 time unit later.
module tb_mem_access_stage;

   logic clk;
   logic rst;
   mem_access_stage_if bus ();
`ifdef MEM_TOHOST_EN
   logic tohost_done;
   logic tohost_pass;
`endif

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic        we;
      logic        exc;
      logic [1:0]  cause;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        chk_data;
   } exp_t;

   exp_t exp_q[$];

   mem_access_stage #(.TOHOST_ADDR(32'h0000_1000)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus)
`ifdef MEM_TOHOST_EN
      ,
      .tohost_done (tohost_done),
      .tohost_pass (tohost_pass)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle_inputs();
      bus.ex_valid    = 1'b0;
      bus.ex_op       = 2'd0;
      bus.ex_funct3   = 3'd0;
      bus.ex_addr     = 32'd0;
      bus.ex_wdata    = 32'd0;
      bus.ex_result   = 32'd0;
      bus.ex_rd       = 5'd0;
      bus.dmem_gnt    = 1'b1;
      bus.dmem_rvalid = 1'b0;
      bus.dmem_rdata  = 32'd0;
      bus.wb_ready    = 1'b1;
   endtask

   task automatic drive_op(input logic [1:0] op, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] result, input logic [4:0] rd);
      bus.ex_valid  = 1'b1;
      bus.ex_op     = op;
      bus.ex_funct3 = f3;
      bus.ex_addr   = addr;
      bus.ex_wdata  = wdata;
      bus.ex_result = result;
      bus.ex_rd     = rd;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({bus.wb_valid, bus.wb_we, bus.wb_exc, bus.wb_exc_cause, bus.wb_rd, bus.wb_data, bus.dmem_req} !== 42'd0)
         begin failures++; $display("FAIL reset_outputs got=%h exp=0", {bus.wb_valid, bus.wb_we, bus.wb_exc, bus.wb_exc_cause, bus.wb_rd, bus.wb_data, bus.dmem_req}); end
`ifdef MEM_TOHOST_EN
      checks++;
      if ({tohost_done, tohost_pass} !== 2'b00)
         begin failures++; $display("FAIL reset_tohost got=%b exp=00", {tohost_done, tohost_pass}); end
`endif
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (bus.ex_ready !== 1'b1)
         begin failures++; $display("FAIL reset_ex_ready got=%b exp=1", bus.ex_ready); end
   endtask

   task automatic test_store_sb();
      idle_inputs();
      @(negedge clk);
      drive_op(2'd2, 3'd0, 32'h103, 32'hA5, 32'h0, 5'd0);
      #1;
      checks++;
      if ({bus.dmem_req, bus.dmem_we, bus.dmem_be, bus.dmem_addr, bus.dmem_wdata, bus.ex_ready} !== {1'b1, 1'b1, 4'b1000, 32'h100, 32'hA5A5A5A5, 1'b1})
         begin failures++; $display("FAIL sb_request got=%h exp=%h", {bus.dmem_req, bus.dmem_we, bus.dmem_be, bus.dmem_addr, bus.dmem_wdata, bus.ex_ready}, {1'b1, 1'b1, 4'b1000, 32'h100, 32'hA5A5A5A5, 1'b1}); end
      @(negedge clk);
      bus.ex_valid = 1'b0;
      #1;
      checks++;
      if ({bus.wb_valid, bus.wb_we, bus.wb_exc} !== 3'b100)
         begin failures++; $display("FAIL sb_wb got=%b exp=100", {bus.wb_valid, bus.wb_we, bus.wb_exc}); end
      @(negedge clk);
      #1;
      checks++;
      if (bus.wb_valid !== 1'b0)
         begin failures++; $display("FAIL sb_drain got=%b exp=0", bus.wb_valid); end
   endtask

   task automatic test_load_ext();
      logic [2:0]  f3;
      logic [31:0] expv;
      for (int i = 0; i < 2; i++) begin
         f3   = (i == 0) ? 3'd0 : 3'd4;
         expv = (i == 0) ? 32'hFFFFFF80 : 32'h00000080;
         idle_inputs();
         @(negedge clk);
         drive_op(2'd1, f3, 32'h102, 32'h0, 32'h0, 5'd7);
         #1;
         checks++;
         if ({bus.dmem_req, bus.dmem_we, bus.dmem_be, bus.dmem_addr, bus.ex_ready} !== {1'b1, 1'b0, 4'b0100, 32'h100, 1'b1})
            begin failures++; $display("FAIL load_request i=%0d got=%h exp=%h", i, {bus.dmem_req, bus.dmem_we, bus.dmem_be, bus.dmem_addr, bus.ex_ready}, {1'b1, 1'b0, 4'b0100, 32'h100, 1'b1}); end
         // A second load is held at the input while the first one waits
         for (int w = 0; w < 3; w++) begin
            @(negedge clk);
            drive_op(2'd1, 3'd2, 32'h200, 32'h0, 32'h0, 5'd8);
            if (w == 2) begin
               bus.dmem_rvalid = 1'b1;
               bus.dmem_rdata  = 32'h0080FF00;
            end
            #1;
            checks++;
            if ({bus.ex_ready, bus.dmem_req, bus.wb_valid} !== 3'b000)
               begin failures++; $display("FAIL load_wait i=%0d w=%0d got=%b exp=000", i, w, {bus.ex_ready, bus.dmem_req, bus.wb_valid}); end
         end
         @(negedge clk);
         bus.dmem_rvalid = 1'b0;
         bus.ex_valid    = 1'b0;
         #1;
         checks++;
         if ({bus.wb_valid, bus.wb_we, bus.wb_exc, bus.wb_rd, bus.wb_data} !== {1'b1, 1'b1, 1'b0, 5'd7, expv})
            begin failures++; $display("FAIL load_result i=%0d got=%h exp=%h", i, {bus.wb_valid, bus.wb_we, bus.wb_exc, bus.wb_rd, bus.wb_data}, {1'b1, 1'b1, 1'b0, 5'd7, expv}); end
         @(negedge clk);
      end
   endtask

   task automatic test_exceptions();
      logic [1:0]  t_op    [4] = '{2'd1, 2'd2, 2'd1, 2'd2};
      logic [2:0]  t_f3    [4] = '{3'd1, 3'd2, 3'd3, 3'd5};
      logic [31:0] t_addr  [4] = '{32'h101, 32'h102, 32'h100, 32'h101};
      logic [1:0]  t_cause [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
      idle_inputs();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive_op(t_op[i], t_f3[i], t_addr[i], 32'h0, 32'h0, 5'd3);
         #1;
         checks++;
         if ({bus.dmem_req, bus.ex_ready} !== 2'b01)
            begin failures++; $display("FAIL exc_accept i=%0d got=%b exp=01", i, {bus.dmem_req, bus.ex_ready}); end
         @(negedge clk);
         bus.ex_valid = 1'b0;
         #1;
         checks++;
         if ({bus.wb_valid, bus.wb_we, bus.wb_exc, bus.wb_exc_cause} !== {3'b101, t_cause[i]})
            begin failures++; $display("FAIL exc_result i=%0d got=%b exp=%b", i, {bus.wb_valid, bus.wb_we, bus.wb_exc, bus.wb_exc_cause}, {3'b101, t_cause[i]}); end
      end
   endtask

   task automatic test_backpressure();
      idle_inputs();
      @(negedge clk);
      drive_op(2'd0, 3'd0, 32'h0, 32'h0, 32'h1234, 5'd5);
      #1;
      checks++;
      if (bus.ex_ready !== 1'b1)
         begin failures++; $display("FAIL bp_first_accept got=%b exp=1", bus.ex_ready); end
      @(negedge clk);
      bus.wb_ready = 1'b0;
      drive_op(2'd0, 3'd0, 32'h0, 32'h0, 32'h5678, 5'd6);
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++;
         if ({bus.wb_valid, bus.wb_we, bus.wb_rd, bus.wb_data, bus.ex_ready} !== {1'b1, 1'b1, 5'd5, 32'h1234, 1'b0})
            begin failures++; $display("FAIL bp_hold k=%0d got=%h exp=%h", k, {bus.wb_valid, bus.wb_we, bus.wb_rd, bus.wb_data, bus.ex_ready}, {1'b1, 1'b1, 5'd5, 32'h1234, 1'b0}); end
         @(negedge clk);
      end
      bus.wb_ready = 1'b1;
      #1;
      checks++;
      if (bus.ex_ready !== 1'b1)
         begin failures++; $display("FAIL bp_release_accept got=%b exp=1", bus.ex_ready); end
      @(negedge clk);
      bus.ex_valid = 1'b0;
      #1;
      checks++;
      if ({bus.wb_valid, bus.wb_we, bus.wb_rd, bus.wb_data} !== {1'b1, 1'b1, 5'd6, 32'h5678})
         begin failures++; $display("FAIL bp_next_result got=%h exp=%h", {bus.wb_valid, bus.wb_we, bus.wb_rd, bus.wb_data}, {1'b1, 1'b1, 5'd6, 32'h5678}); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_load();
      idle_inputs();
      @(negedge clk);
      drive_op(2'd1, 3'd2, 32'h100, 32'h0, 32'h0, 5'd9);
      #1;
      checks++;
      if (bus.dmem_req !== 1'b1)
         begin failures++; $display("FAIL rml_request got=%b exp=1", bus.dmem_req); end
      @(negedge clk);
      bus.ex_valid = 1'b0;
      rst = 1'b0;
      #1;
      checks++;
      if ({bus.wb_valid, bus.wb_we, bus.wb_exc} !== 3'b000)
         begin failures++; $display("FAIL rml_in_reset got=%b exp=000", {bus.wb_valid, bus.wb_we, bus.wb_exc}); end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      bus.dmem_rvalid = 1'b1;
      bus.dmem_rdata  = 32'hDEADBEEF;
      #1;
      checks++;
      if (bus.ex_ready !== 1'b1)
         begin failures++; $display("FAIL rml_idle got=%b exp=1", bus.ex_ready); end
      @(negedge clk);
      bus.dmem_rvalid = 1'b0;
      #1;
      checks++;
      if (bus.wb_valid !== 1'b0)
         begin failures++; $display("FAIL rml_stray_ignored got=%b exp=0", bus.wb_valid); end
   endtask

`ifdef MEM_TOHOST_EN
   task automatic test_tohost();
      logic [31:0] t_addr [3] = '{32'h1004, 32'h1000, 32'h1000};
      logic [31:0] t_data [3] = '{32'h1, 32'h1, 32'h3};
      logic [1:0]  t_exp  [3] = '{2'b00, 2'b11, 2'b11};
      idle_inputs();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive_op(2'd2, 3'd2, t_addr[i], t_data[i], 32'h0, 5'd0);
         @(negedge clk);
         bus.ex_valid = 1'b0;
         #1;
         checks++;
         if ({tohost_done, tohost_pass} !== t_exp[i])
            begin failures++; $display("FAIL tohost i=%0d got=%b exp=%b", i, {tohost_done, tohost_pass}, t_exp[i]); end
      end
   endtask
`endif

   task automatic test_random();
      logic        have_op;
      logic        load_out;
      int          lat;
      logic [2:0]  lf3;
      logic [1:0]  loff;
      logic [4:0]  lrd;
      logic [1:0]  op;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] result;
      logic [4:0]  rd;
      logic        ill, mis, memop, out_free_m, exp_rdy, exp_req;
      logic [3:0]  exp_be;
      logic [31:0] exp_wd;
      logic [31:0] sh;
      logic [31:0] v;
      int          bytes;
      exp_t        e;
      have_op  = 1'b0;
      load_out = 1'b0;
      lat = 0; lf3 = 3'd0; loff = 2'd0; lrd = 5'd0;
      op = 2'd0; f3 = 3'd0; addr = 32'd0; wdata = 32'd0; result = 32'd0; rd = 5'd0;
      idle_inputs();
      @(negedge clk);
      exp_q.delete();
      for (int cyc = 0; cyc < 3000 || have_op || load_out || exp_q.size() != 0; cyc++) begin
         if (cyc >= 3300) begin
            checks++; failures++;
            $display("FAIL random_drain_timeout got=pending exp=drained");
            break;
         end
         @(negedge clk);
         if (!have_op && cyc < 3000 && $urandom_range(3) != 0) begin
            have_op = 1'b1;
            op      = 2'($urandom_range(3));
            f3      = 3'($urandom_range(7));
            addr    = $urandom & 32'h0000_0FFF;
            wdata   = $urandom;
            result  = $urandom;
            rd      = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom_range(31));
            drive_op(op, f3, addr, wdata, result, rd);
         end
         bus.ex_valid   = have_op;
         bus.dmem_gnt   = ($urandom_range(2) != 0);
         bus.wb_ready   = ($urandom_range(2) != 0);
         bus.dmem_rdata = $urandom;
         if (load_out) begin
            bus.dmem_rvalid = (lat == 0);
            if (lat != 0) lat--;
         end else begin
            bus.dmem_rvalid = ($urandom_range(7) == 0);
         end
         #1;
         // WB slot as seen by the model
         checks++;
         if (bus.wb_valid !== (exp_q.size() != 0))
            begin failures++; $display("FAIL random_wb_valid cyc=%0d got=%b exp=%b", cyc, bus.wb_valid, exp_q.size() != 0); end
         if (exp_q.size() != 0) begin
            e = exp_q[0];
            checks++;
            if ({bus.wb_we, bus.wb_exc, bus.wb_exc_cause} !== {e.we, e.exc, e.cause})
               begin failures++; $display("FAIL random_wb_flags cyc=%0d got=%b exp=%b", cyc, {bus.wb_we, bus.wb_exc, bus.wb_exc_cause}, {e.we, e.exc, e.cause}); end
            if (e.chk_data) begin
               checks++;
               if ({bus.wb_rd, bus.wb_data} !== {e.rd, e.data})
                  begin failures++; $display("FAIL random_wb_data cyc=%0d got=%h exp=%h", cyc, {bus.wb_rd, bus.wb_data}, {e.rd, e.data}); end
            end
         end
         // Classify the presented op from the ISA rules
         ill   = (op == 2'd1 && (f3 == 3'd3 || f3 >= 3'd6)) || (op == 2'd2 && f3 > 3'd2);
         bytes = 1 << f3[1:0];
         mis   = (op == 2'd1 || op == 2'd2) && !ill && ((addr % bytes) != 0);
         memop = (op == 2'd1 || op == 2'd2) && !ill && !mis;
         out_free_m = (exp_q.size() == 0) || bus.wb_ready;
         exp_rdy = !load_out && out_free_m && (!memop || bus.dmem_gnt);
         exp_req = have_op && !load_out && out_free_m && memop;
         checks++;
         if ({bus.ex_ready, bus.dmem_req} !== {exp_rdy, exp_req})
            begin failures++; $display("FAIL random_handshake cyc=%0d got=%b exp=%b", cyc, {bus.ex_ready, bus.dmem_req}, {exp_rdy, exp_req}); end
         if (exp_req) begin
            exp_be = 4'(((1 << bytes) - 1) << addr[1:0]);
            for (int k = 0; k < 4; k++) exp_wd[8*k +: 8] = 8'(wdata >> (8 * (k % bytes)));
            checks++;
            if ({bus.dmem_we, bus.dmem_be, bus.dmem_addr} !== {op == 2'd2, exp_be, addr & 32'hFFFF_FFFC})
               begin failures++; $display("FAIL random_dmem_req cyc=%0d got=%h exp=%h", cyc, {bus.dmem_we, bus.dmem_be, bus.dmem_addr}, {op == 2'd2, exp_be, addr & 32'hFFFF_FFFC}); end
            if (op == 2'd2) begin
               checks++;
               if (bus.dmem_wdata !== exp_wd)
                  begin failures++; $display("FAIL random_dmem_wdata cyc=%0d got=%h exp=%h", cyc, bus.dmem_wdata, exp_wd); end
            end
         end
         // Advance the model across the coming clock edge
         if (exp_q.size() != 0 && bus.wb_ready) void'(exp_q.pop_front());
         if (load_out && bus.dmem_rvalid) begin
            sh = bus.dmem_rdata >> (8 * loff);
            case (lf3[1:0])
               2'd0: begin v = sh & 32'hFF;   if (!lf3[2] && sh[7])  v = v | 32'hFFFF_FF00; end
               2'd1: begin v = sh & 32'hFFFF; if (!lf3[2] && sh[15]) v = v | 32'hFFFF_0000; end
               default: v = bus.dmem_rdata;
            endcase
            exp_q.push_back('{we: (lrd != 0), exc: 1'b0, cause: 2'd0, rd: lrd, data: v, chk_data: 1'b1});
            load_out = 1'b0;
         end
         if (have_op && exp_rdy) begin
            have_op = 1'b0;
            if (op == 2'd1 && memop) begin
               load_out = 1'b1;
               lat  = $urandom_range(3);
               lf3  = f3;
               loff = addr[1:0];
               lrd  = rd;
            end else if (ill) begin
               exp_q.push_back('{we: 1'b0, exc: 1'b1, cause: 2'd3, rd: rd, data: 32'd0, chk_data: 1'b0});
            end else if (mis) begin
               exp_q.push_back('{we: 1'b0, exc: 1'b1, cause: (op == 2'd1) ? 2'd1 : 2'd2, rd: rd, data: 32'd0, chk_data: 1'b0});
            end else if (op == 2'd2) begin
               exp_q.push_back('{we: 1'b0, exc: 1'b0, cause: 2'd0, rd: rd, data: 32'd0, chk_data: 1'b0});
            end else begin
               exp_q.push_back('{we: (rd != 0), exc: 1'b0, cause: 2'd0, rd: rd, data: result, chk_data: 1'b1});
            end
         end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_store_sb();
      test_load_ext();
      test_exceptions();
      test_backpressure();
      test_reset_mid_load();
`ifdef MEM_TOHOST_EN
      test_tohost();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
